devil_cr_responder: RTL and testbench
=====================================

Name: devil_cr_responder

Overview:
- Snoop-response stage of the devil block: consumes ACE AC-channel snoop requests and produces the CR-channel response.
- Filters each snoop by ACSNOOP value and by an address window. For matching snoops it waits a programmable delay, then answers with a programmed CRRESP.
- Runs in one-shot (OSH) or continuous (CON) mode. Non-matching snoops get a benign response, so the interconnect never stalls.
- Configuration comes from the AXI4-Lite register file (CTRL/DELAY/ACSNOOP/BASE_ADDR/MEM_SIZE/STATUS).

Parameters:
- ADDR_W, 44, AC address width
- SNOOP_W, 4, ACSNOOP width
- CRRESP_W, 5, CRRESP width
- CNT_W, 32, width of delay input and match counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_en  in  1  CTRL.EN; tampering enable
- i_func  in  1  0 = OSH (one-shot), 1 = CON (continuous)
- i_acflt_en  in  1  CTRL.ACFLT; enable ACSNOOP filter
- i_addrflt_en  in  1  CTRL.ADDRFLT; enable address-window filter
- i_acsnoop_flt  in  SNOOP_W  ACSNOOP register value to match
- i_base_addr  in  32  BASE_ADDR register, zero-extended to ADDR_W
- i_mem_size  in  32  MEM_SIZE register
- i_delay  in  CNT_W  DELAY register, cycles
- i_crresp  in  CRRESP_W  CTRL.CRRESP value driven on tampered responses
- i_done_clr  in  1  STATUS write-1-to-clear pulse
- acvalid  in  1  AC valid
- acready  out  1  AC ready
- acaddr  in  ADDR_W  snoop address
- acsnoop  in  SNOOP_W  snoop type
- crvalid  out  1  CR valid
- crready  in  1  CR ready
- crresp  out  CRRESP_W  snoop response
- o_done  out  1  STATUS bit0; set when the OSH shot fires
- o_match_cnt  out  CNT_W  number of tampered responses issued

Behaviour:

Interface and reset:
- One clock, `clk`; reset is synchronous and active-high, port `reset`.
- Reset values: acready=0, crvalid=0, crresp=0, o_done=0, o_match_cnt=0, FSM=IDLE. Reset mid-transaction abandons it immediately, with no CR issued.

FSM states: IDLE, EVAL, WAIT, RESP.
- IDLE: acready=1 (registered, high from the cycle after reset release). Handshake = acvalid & acready at cycle T.
  - At T, latch acaddr, acsnoop, i_en, i_func, i_delay, i_crresp, and both filter enables; go to EVAL.
  - acready drops at T+1.
- EVAL (T+1): compute hit = en_l & !shot_l & snoop_ok & addr_ok.
  - shot_l = OSH mode and o_done already set.
  - snoop_ok = !acflt_l | (acsnoop_l == i_acsnoop_flt).
  - addr_ok = !addrflt_l | (base <= acaddr_l < base + max(i_mem_size,1)).
  - Window arithmetic is done at ADDR_W+1 bits, so there is no wrap. i_mem_size=0 matches only acaddr==base.
  - If hit and delay_l>0, go to WAIT and load counter = delay_l. Otherwise go to RESP.
- WAIT: decrement counter each cycle; at counter==1, go to RESP. Result: crvalid first asserted at T+2+D on a hit (D = delay_l), and at T+2 on a miss.
- RESP: crvalid=1. crresp = hit ? i_crresp_l : 0.
  - Both held stable until crready; crvalid and crresp must not change while crvalid=1 && !crready.
  - On crvalid & crready: crvalid=0 next cycle and return to IDLE (acready=1 next cycle).
  - If the response was a hit: o_match_cnt += 1, saturating at all-ones. In OSH mode, also set o_done.
- Only one snoop is outstanding at a time; AC is back-pressured in every non-IDLE state.
- o_done is sticky until i_done_clr or reset. Set and clear in the same cycle: set wins.
- Config changes after the handshake do not affect the in-flight snoop. i_en=0 makes every later snoop a miss (crresp=0, no delay); the block still completes all handshakes.
- OSH with o_done=1: all snoops are misses until cleared. CON: every hit is tampered, with no limit.

Test Plan:
- Disabled pass-through: i_en=0, snoop acaddr=0x10 → crvalid at T+2, crresp=0, o_match_cnt stays 0, acready back to 1 after the CR handshake.
- CON, no filters: i_en=1, i_func=1, i_delay=2, i_crresp=0x1F, three snoops → each crvalid at T+4 with crresp=0x1F; o_match_cnt=3; o_done=0.
- OSH + clear: i_func=0, i_delay=0, i_crresp=0x09, two snoops → first gets crresp=0x09 and sets o_done=1; second gets crresp=0. Pulse i_done_clr → o_done=0; third snoop gets crresp=0x09 again.
- Filters: base=0x10, size=0x100, acflt and addrflt on, i_acsnoop_flt=1.
  - acaddr=0x10F, acsnoop=1 → hit.
  - acaddr=0x110, acsnoop=1 → miss (upper edge).
  - acaddr=0x0F → miss.
  - acaddr=0x20, acsnoop=0 → miss.
  - Also: size=0, base=0x2, acaddr=0x2 → hit.
- CR back-pressure: hold crready=0 for 5 cycles → crvalid and crresp stable throughout, acready=0 throughout, and a new acvalid is not accepted until the CR handshake completes.
- Reset mid-WAIT: i_delay=100, assert reset 10 cycles after the AC handshake → next cycle crvalid=0, o_match_cnt=0, o_done=0; acready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/devil_cr_responder_if.sv
// rtl/devil_cr_responder_if.sv - ACE AC snoop request / CR snoop response channel bundle
interface devil_cr_responder_if #(
  parameter int ADDR_W   = 44,
  parameter int SNOOP_W  = 4,
  parameter int CRRESP_W = 5
);
  logic                acvalid;
  logic                acready;
  logic [ADDR_W-1:0]   acaddr;
  logic [SNOOP_W-1:0]  acsnoop;
  logic                crvalid;
  logic                crready;
  logic [CRRESP_W-1:0] crresp;

  modport master (
    output acvalid, acaddr, acsnoop, crready,
    input  acready, crvalid, crresp
  );

  modport slave (
    input  acvalid, acaddr, acsnoop, crready,
    output acready, crvalid, crresp
  );
endinterface

// File: rtl/devil_cr_responder.sv
// rtl/devil_cr_responder.sv - snoop responder: filters AC snoops, delays and tampers matching CR responses
module devil_cr_responder #(
  parameter int ADDR_W   = 44,
  parameter int SNOOP_W  = 4,
  parameter int CRRESP_W = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_func,
  input  logic                i_acflt_en,
  input  logic                i_addrflt_en,
  input  logic [SNOOP_W-1:0]  i_acsnoop_flt,
  input  logic [31:0]         i_base_addr,
  input  logic [31:0]         i_mem_size,
  input  logic [CNT_W-1:0]    i_delay,
  input  logic [CRRESP_W-1:0] i_crresp,
  input  logic                i_done_clr,
  devil_cr_responder_if.slave bus,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_match_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                acready_q;
  logic [ADDR_W-1:0]   addr_l;
  logic [SNOOP_W-1:0]  snoop_l;
  logic                en_l, func_l, acflt_l, addrflt_l;
  logic [CNT_W-1:0]    delay_l;
  logic [CRRESP_W-1:0] crresp_l;
  logic [CNT_W-1:0]    cnt;
  logic                hit_q;
  logic [CRRESP_W-1:0] resp_q;

  logic                ac_hs, cr_hs;
  logic                snoop_ok, addr_ok, hit_eval;
  logic [31:0]         size_eff;
  logic [ADDR_W:0]     base_x, end_x, addr_x;

  assign ac_hs = (state == IDLE) && bus.acvalid && acready_q;
  assign cr_hs = (state == RESP) && bus.crready;

  // Window compare one bit wider than the address so base + size cannot wrap.
  assign size_eff = (i_mem_size == 32'd0) ? 32'd1 : i_mem_size;
  assign base_x   = (ADDR_W+1)'(i_base_addr);
  assign end_x    = base_x + (ADDR_W+1)'(size_eff);
  assign addr_x   = {1'b0, addr_l};

  assign snoop_ok = !acflt_l || (snoop_l == i_acsnoop_flt);
  assign addr_ok  = !addrflt_l || ((addr_x >= base_x) && (addr_x < end_x));
  assign hit_eval = en_l && !(!func_l && o_done) && snoop_ok && addr_ok;

  assign bus.acready = acready_q;
  assign bus.crvalid = (state == RESP);
  assign bus.crresp  = resp_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ac_hs) state_nxt = EVAL;
      EVAL: state_nxt = (hit_eval && (delay_l != '0)) ? WAIT : RESP;
      WAIT: if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP: if (bus.crready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acready_q   <= 1'b0;
      addr_l      <= '0;
      snoop_l     <= '0;
      en_l        <= 1'b0;
      func_l      <= 1'b0;
      acflt_l     <= 1'b0;
      addrflt_l   <= 1'b0;
      delay_l     <= '0;
      crresp_l    <= '0;
      cnt         <= '0;
      hit_q       <= 1'b0;
      resp_q      <= '0;
      o_done      <= 1'b0;
      o_match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      acready_q <= (state_nxt == IDLE);

      if (ac_hs) begin
        addr_l    <= bus.acaddr;
        snoop_l   <= bus.acsnoop;
        en_l      <= i_en;
        func_l    <= i_func;
        acflt_l   <= i_acflt_en;
        addrflt_l <= i_addrflt_en;
        delay_l   <= i_delay;
        crresp_l  <= i_crresp;
      end

      if (state == EVAL) begin
        hit_q  <= hit_eval;
        resp_q <= hit_eval ? crresp_l : '0;
        cnt    <= delay_l;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end else if (cr_hs) begin
        resp_q <= '0;
      end

      if (cr_hs && hit_q && (o_match_cnt != '1))
        o_match_cnt <= o_match_cnt + CNT_W'(1);

      // A shot firing in the same cycle as a clear request keeps o_done set.
      if (cr_hs && hit_q && !func_l)
        o_done <= 1'b1;
      else if (i_done_clr)
        o_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_devil_cr_responder.sv
// tb/tb_devil_cr_responder.sv - directed vector bench for devil_cr_responder
module tb_devil_cr_responder;

  logic        clk = 0;
  logic        reset;
  logic        i_en, i_func, i_acflt_en, i_addrflt_en, i_done_clr;
  logic [3:0]  i_acsnoop_flt;
  logic [31:0] i_base_addr, i_mem_size, i_delay;
  logic [4:0]  i_crresp;
  logic        o_done;
  logic [31:0] o_match_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  devil_cr_responder_if #(.ADDR_W(44), .SNOOP_W(4), .CRRESP_W(5)) bus ();

  devil_cr_responder #(.ADDR_W(44), .SNOOP_W(4), .CRRESP_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_en(i_en), .i_func(i_func), .i_acflt_en(i_acflt_en), .i_addrflt_en(i_addrflt_en),
    .i_acsnoop_flt(i_acsnoop_flt), .i_base_addr(i_base_addr), .i_mem_size(i_mem_size),
    .i_delay(i_delay), .i_crresp(i_crresp), .i_done_clr(i_done_clr),
    .bus(bus), .o_done(o_done), .o_match_cnt(o_match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, func, acflt, addrflt;
    logic [3:0]  flt;
    logic [31:0] base, size, delay;
    logic [4:0]  cfg;
    logic [43:0] addr;
    logic [3:0]  snoop;
    logic [4:0]  exp_resp;
    int          exp_lat;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns at the falling edge just after the AC handshake edge.
  task automatic ac_send(input logic [43:0] a, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    bus.acvalid = 1'b1;
    bus.acaddr  = a;
    bus.acsnoop = s;
    while (!bus.acready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ac_accept", bus.acready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.acvalid = 1'b0;
    check("ac_ready_drop", bus.acready, 0);
  endtask

  // lat = edges after the AC handshake until crvalid is seen.
  task automatic wait_cr(output int lat);
    int k = 1;
    while (!bus.crvalid && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!bus.crvalid) check("cr_timeout", bus.crvalid, 1);
    lat = k;
  endtask

  task automatic cr_take();
    bus.crready = 1'b1;
    @(negedge clk);
    bus.crready = 1'b0;
    check("cr_done_valid", bus.crvalid, 0);
    check("ac_ready_back", bus.acready, 1);
  endtask

  task automatic snoop(input string nm, input logic [43:0] a, input logic [3:0] s,
                       input logic [4:0] exp_resp, input int exp_lat);
    int lat;
    ac_send(a, s);
    wait_cr(lat);
    check({nm, "_lat"}, lat, exp_lat);
    check({nm, "_resp"}, bus.crresp, exp_resp);
    cr_take();
  endtask

  initial begin
    int lat;
    logic [4:0] held;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,   32'd5, 5'h1F, 44'h10,  4'h0, 5'h00, 2, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,   32'd2, 5'h1F, 44'h10,  4'h0, 5'h1F, 4, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,   32'd2, 5'h1F, 44'h500, 4'h7, 5'h1F, 4, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,   32'd2, 5'h1F, 44'hFFF_FFFF_FFFF, 4'hF, 5'h1F, 4, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 32'h10, 32'h100, 32'd1, 5'h0A, 44'h10F, 4'h1, 5'h0A, 3, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 32'h10, 32'h100, 32'd1, 5'h0A, 44'h110, 4'h1, 5'h00, 2, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 32'h10, 32'h100, 32'd1, 5'h0A, 44'h0F,  4'h1, 5'h00, 2, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 32'h10, 32'h100, 32'd1, 5'h0A, 44'h20,  4'h0, 5'h00, 2, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 32'h2,  32'h0,   32'd1, 5'h0A, 44'h2,   4'h1, 5'h0A, 3, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 32'h2,  32'h0,   32'd1, 5'h0A, 44'h3,   4'h1, 5'h00, 2, 1'b0};

    reset = 1; i_en = 0; i_func = 0; i_acflt_en = 0; i_addrflt_en = 0; i_done_clr = 0;
    i_acsnoop_flt = 0; i_base_addr = 0; i_mem_size = 0; i_delay = 0; i_crresp = 0;
    bus.acvalid = 0; bus.acaddr = 0; bus.acsnoop = 0; bus.crready = 0;

    repeat (3) @(negedge clk);
    check("rst_acready", bus.acready, 0);
    check("rst_crvalid", bus.crvalid, 0);
    check("rst_crresp", bus.crresp, 0);
    check("rst_done", o_done, 0);
    check("rst_cnt", o_match_cnt, 0);
    reset = 0;
    @(negedge clk);
    check("rel_acready", bus.acready, 1);

    for (int i = 0; i < 10; i++) begin
      i_en = vecs[i].en; i_func = vecs[i].func;
      i_acflt_en = vecs[i].acflt; i_addrflt_en = vecs[i].addrflt;
      i_acsnoop_flt = vecs[i].flt; i_base_addr = vecs[i].base; i_mem_size = vecs[i].size;
      i_delay = vecs[i].delay; i_crresp = vecs[i].cfg;
      ac_send(vecs[i].addr, vecs[i].snoop);
      wait_cr(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_resp", i), bus.crresp, vecs[i].exp_resp);
      cr_take();
      if (vecs[i].exp_hit) exp_cnt++;
      check($sformatf("v%0d_cnt", i), o_match_cnt, exp_cnt);
      check($sformatf("v%0d_done", i), o_done, 0);
    end

    // One-shot: fires once, blocked until cleared, then fires again.
    i_en = 1; i_func = 0; i_acflt_en = 0; i_addrflt_en = 0; i_delay = 0; i_crresp = 5'h09;
    snoop("osh1", 44'h40, 4'h0, 5'h09, 2);
    exp_cnt++;
    check("osh1_done", o_done, 1);
    snoop("osh2", 44'h40, 4'h0, 5'h00, 2);
    check("osh2_done", o_done, 1);
    check("osh2_cnt", o_match_cnt, exp_cnt);
    @(negedge clk); i_done_clr = 1;
    @(negedge clk); i_done_clr = 0;
    check("osh_clr_done", o_done, 0);
    snoop("osh3", 44'h40, 4'h0, 5'h09, 2);
    exp_cnt++;
    check("osh3_done", o_done, 1);
    check("osh3_cnt", o_match_cnt, exp_cnt);

    // CR back-pressure with a second snoop waiting on AC.
    i_func = 1; i_delay = 3; i_crresp = 5'h15;
    ac_send(44'h80, 4'h2);
    wait_cr(lat);
    check("bp_lat", lat, 5);
    held = bus.crresp;
    check("bp_resp", held, 5'h15);
    bus.acvalid = 1; bus.acaddr = 44'h90; bus.acsnoop = 4'h3;
    i_crresp = 5'h03;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", c), bus.crvalid, 1);
      check($sformatf("bp_hold%0d", c), bus.crresp, 5'h15);
      check($sformatf("bp_acrdy%0d", c), bus.acready, 0);
    end
    bus.crready = 1;
    @(negedge clk);
    bus.crready = 0;
    exp_cnt++;
    check("bp_acready_back", bus.acready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.acvalid = 0;
    check("bp2_accepted", bus.acready, 0);
    wait_cr(lat);
    check("bp2_lat", lat, 5);
    check("bp2_resp", bus.crresp, 5'h03);
    cr_take();
    exp_cnt++;
    check("bp2_cnt", o_match_cnt, exp_cnt);

    // Reset ten cycles after the handshake, while counting down.
    i_delay = 100; i_func = 0; i_crresp = 5'h11;
    ac_send(44'hA0, 4'h0);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("rw_crvalid", bus.crvalid, 0);
    check("rw_cnt", o_match_cnt, 0);
    check("rw_done", o_done, 0);
    check("rw_acready", bus.acready, 0);
    reset = 0;
    @(negedge clk);
    check("rw_acready_rel", bus.acready, 1);
    check("rw_crvalid_rel", bus.crvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
